apb_timer_slave: RTL and testbench

APB3 completer that hangs off a mux PSEL output as a third peripheral, alongside slave1/slave2. It consumes the master's PENABLE/PWRITE/PADDR/PSTRB/PWDATA and returns PREADY/PRDATA to the mux.
It contains a 32-bit programmable down-counter timer with one-shot/auto-reload modes, a sticky expiry flag and a level interrupt.
APB access phase is stretched by a parameterised wait-state FSM.

---
 rtl/apb_timer_slave_pkg.sv | 33 +++
 rtl/apb_timer_slave_if.sv | 28 ++
 rtl/apb_timer_counter.sv | 52 +++++
 rtl/apb_timer_slave.sv | 173 +++++++++++++++++
 tb/tb_apb_timer_slave.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_timer_slave_pkg.sv
// Shared definitions for the APB timer completer: register map, CTRL bit
// positions, access FSM encoding and the byte-lane merge helper.
package apb_timer_pkg;

  localparam int unsigned CTRL_OFF   = 32'h0000_0000;
  localparam int unsigned LOAD_OFF   = 32'h0000_0004;
  localparam int unsigned COUNT_OFF  = 32'h0000_0008;
  localparam int unsigned STATUS_OFF = 32'h0000_000C;

  localparam int unsigned CTRL_EN_BIT     = 32'd0;
  localparam int unsigned CTRL_AR_BIT     = 32'd1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 32'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_slave_if.sv
// APB3 completer-side bus bundle for the timer. PSLVERR exists only when
// APB_TIMER_PSLVERR_EN is defined.
interface apb_timer_slave_if #(
  parameter int ADDWIDTH  = 8,
  parameter int DATAWIDTH = 32
);
  logic                   PSEL;
  logic                   PENABLE;
  logic                   PWRITE;
  logic [ADDWIDTH-1:0]    PADDR;
  logic [DATAWIDTH/8-1:0] PSTRB;
  logic [DATAWIDTH-1:0]   PWDATA;
  logic                   PREADY;
  logic [DATAWIDTH-1:0]   PRDATA;
`ifdef APB_TIMER_PSLVERR_EN
  logic                   PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
                  input  PREADY, PRDATA, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
                  output PREADY, PRDATA, PSLVERR);
`else
  modport master (output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
                  input  PREADY, PRDATA);
  modport slave  (input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
                  output PREADY, PRDATA);
`endif
endinterface

// File: rtl/apb_timer_counter.sv
// 32-bit down-counter with one-shot/auto-reload and a sticky EXPIRED flag.
// A software load beats the decrement; a hardware expiry beats a W1C clear.
module apb_timer_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_reload,
  input  logic        load_we,
  input  logic [31:0] load_val,
  input  logic [31:0] reload_val,
  input  logic        w1c,
  output logic [31:0] count,
  output logic        expired
);

  logic [31:0] count_r;
  logic        expired_r;
  logic        expire_s;

  // A load cycle suppresses the decrement, and therefore any expiry.
  assign expire_s = ~load_we & en & (count_r == 32'd1);

  // Counter and sticky expiry flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r   <= 32'd0;
      expired_r <= 1'b0;
    end else begin
      if (load_we) begin
        count_r <= load_val;
      end else if (expire_s) begin
        count_r <= auto_reload ? reload_val : 32'd0;
      end else if (en && (count_r > 32'd1)) begin
        count_r <= count_r - 32'd1;
      end else begin
        count_r <= count_r;
      end

      if (expire_s) begin
        expired_r <= 1'b1;
      end else if (w1c) begin
        expired_r <= 1'b0;
      end else begin
        expired_r <= expired_r;
      end
    end
  end

  assign count   = count_r;
  assign expired = expired_r;

endmodule

// File: rtl/apb_timer_slave.sv
// APB3 timer completer: wait-state access FSM, register decode, level IRQ.
// Optional PSLVERR reporting is enabled with APB_TIMER_PSLVERR_EN.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter int ADDWIDTH    = 8,
  parameter int DATAWIDTH   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_timer_slave_if.slave  apb,
  output logic              IRQ
);

  apb_state_e           state_r, state_nxt_s;
  logic [3:0]           wcnt_r;
  logic                 pready_r, pready_nxt_s;
  logic [DATAWIDTH-1:0] prdata_r, prdata_nxt_s, rdata_s;
  logic [2:0]           ctrl_r, ctrl_wdata_s;
  logic [DATAWIDTH-1:0] load_r, load_wdata_s, count_s;
  logic                 expired_s, irq_r;
  logic [ADDWIDTH-1:0]  addr_off_s;
  logic                 sel_ctrl_s, sel_load_s, sel_count_s, sel_status_s;
  logic                 wr_commit_s, ctrl_we_s, load_we_s, w1c_s;
  logic                 en_rise_s, cnt_load_s;
  logic [DATAWIDTH-1:0] cnt_load_val_s;
  logic                 unused_s;

  assign unused_s     = ^apb.PADDR[1:0];
  assign addr_off_s   = {apb.PADDR[ADDWIDTH-1:2], 2'b00};
  assign sel_ctrl_s   = (addr_off_s == ADDWIDTH'(CTRL_OFF));
  assign sel_load_s   = (addr_off_s == ADDWIDTH'(LOAD_OFF));
  assign sel_count_s  = (addr_off_s == ADDWIDTH'(COUNT_OFF));
  assign sel_status_s = (addr_off_s == ADDWIDTH'(STATUS_OFF));

  // Writes land on the edge closing ACCESS; an all-zero PSTRB touches nothing.
  assign wr_commit_s  = (state_r == ACCESS) & apb.PSEL & apb.PWRITE & (|apb.PSTRB);
  assign ctrl_we_s    = wr_commit_s & sel_ctrl_s;
  assign load_we_s    = wr_commit_s & sel_load_s;
  assign w1c_s        = wr_commit_s & sel_status_s & apb.PSTRB[0] & apb.PWDATA[0];
  assign ctrl_wdata_s = apb.PSTRB[0] ? apb.PWDATA[2:0] : ctrl_r;
  assign load_wdata_s = apply_strb(load_r, apb.PWDATA, apb.PSTRB);

  assign en_rise_s      = ctrl_we_s & ~ctrl_r[CTRL_EN_BIT] & ctrl_wdata_s[CTRL_EN_BIT];
  assign cnt_load_s     = load_we_s | en_rise_s;
  assign cnt_load_val_s = load_we_s ? load_wdata_s : load_r;

  // Read data mux over the current register values.
  always_comb begin
    rdata_s = {DATAWIDTH{1'b0}};
    if (sel_ctrl_s) begin
      rdata_s = {{(DATAWIDTH-3){1'b0}}, ctrl_r};
    end else if (sel_load_s) begin
      rdata_s = load_r;
    end else if (sel_count_s) begin
      rdata_s = count_s;
    end else if (sel_status_s) begin
      rdata_s = {{(DATAWIDTH-1){1'b0}}, expired_s};
    end else begin
      rdata_s = {DATAWIDTH{1'b0}};
    end
  end

  // Access FSM next state; losing PSEL mid-transfer drops back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (apb.PSEL && !apb.PENABLE) begin
          state_nxt_s = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!apb.PSEL) begin
          state_nxt_s = IDLE;
        end else if (wcnt_r <= 4'd1) begin
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      ACCESS:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output values for the coming cycle; PRDATA is captured on ACCESS entry.
  always_comb begin
    pready_nxt_s = 1'b0;
    prdata_nxt_s = {DATAWIDTH{1'b0}};
    if (state_nxt_s == ACCESS) begin
      pready_nxt_s = 1'b1;
      prdata_nxt_s = apb.PWRITE ? {DATAWIDTH{1'b0}} : rdata_s;
    end else begin
      pready_nxt_s = 1'b0;
      prdata_nxt_s = {DATAWIDTH{1'b0}};
    end
  end

  // FSM state, wait-state counter and registered bus outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r  <= IDLE;
      wcnt_r   <= 4'd0;
      pready_r <= 1'b0;
      prdata_r <= {DATAWIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      pready_r <= pready_nxt_s;
      prdata_r <= prdata_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s == WAIT)) begin
        wcnt_r <= 4'(WAIT_CYCLES);
      end else if ((state_r == WAIT) && (wcnt_r != 4'd0)) begin
        wcnt_r <= wcnt_r - 4'd1;
      end else begin
        wcnt_r <= wcnt_r;
      end
    end
  end

  // Software-visible CTRL/LOAD registers and the registered interrupt.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_r <= 3'd0;
      load_r <= {DATAWIDTH{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      ctrl_r <= ctrl_we_s ? ctrl_wdata_s : ctrl_r;
      load_r <= load_we_s ? load_wdata_s : load_r;
      irq_r  <= expired_s & ctrl_r[CTRL_IRQ_EN_BIT];
    end
  end

  apb_timer_counter u_counter (
    .clk         (PCLK),
    .rst         (PRESET),
    .en          (ctrl_r[CTRL_EN_BIT]),
    .auto_reload (ctrl_r[CTRL_AR_BIT]),
    .load_we     (cnt_load_s),
    .load_val    (cnt_load_val_s),
    .reload_val  (load_r),
    .w1c         (w1c_s),
    .count       (count_s),
    .expired     (expired_s)
  );

  assign apb.PREADY = pready_r;
  assign apb.PRDATA = prdata_r;
  assign IRQ        = irq_r;

`ifdef APB_TIMER_PSLVERR_EN
  logic pslverr_r;
  logic err_s;

  assign err_s = ~(sel_ctrl_s | sel_load_s | sel_count_s | sel_status_s)
               | (apb.PWRITE & sel_count_s);

  // Error response travels with PREADY for unmapped or read-only targets.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pslverr_r <= 1'b0;
    end else begin
      pslverr_r <= (state_nxt_s == ACCESS) & err_s;
    end
  end

  assign apb.PSLVERR = pslverr_r;
`endif

endmodule

// File: tb/tb_apb_timer_slave.sv
// Randomised scoreboard bench for apb_timer_slave with a cycle-level reference model.
module tb_apb_timer_slave;

  localparam int WC = 2;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic IRQ;

  always #5 PCLK = ~PCLK;

  apb_timer_slave_if #(.ADDWIDTH(8), .DATAWIDTH(32)) apb ();

  apb_timer_slave #(.ADDWIDTH(8), .DATAWIDTH(32), .WAIT_CYCLES(WC)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb), .IRQ(IRQ)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_load, m_count;
  logic        m_exp, m_irq;
  int          cyc = 0;
  int          pend_at = -1;
  logic [7:0]  pend_addr;
  logic [31:0] pend_data;
  logic [3:0]  pend_strb;

  logic [2:0]  t_ctrl;
  logic [31:0] t_load, t_cnt;
  logic        t_loaded, t_set, t_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timer rules applied once per clock on the values held before the edge.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      m_ctrl = 3'd0; m_load = 32'd0; m_count = 32'd0; m_exp = 1'b0; m_irq = 1'b0;
    end else begin
      t_ctrl = m_ctrl; t_load = m_load; t_cnt = m_count;
      t_loaded = 1'b0; t_set = 1'b0; t_clr = 1'b0;
      if (pend_at == cyc && pend_strb != 4'd0) begin
        case (pend_addr & 8'hFC)
          8'h00: if (pend_strb[0]) begin
            t_ctrl = pend_data[2:0];
            if (!m_ctrl[0] && t_ctrl[0]) begin t_cnt = m_load; t_loaded = 1'b1; end
          end
          8'h04: begin
            for (int b = 0; b < 4; b++)
              if (pend_strb[b]) t_load[8*b +: 8] = pend_data[8*b +: 8];
            t_cnt = t_load; t_loaded = 1'b1;
          end
          8'h0C: t_clr = pend_strb[0] & pend_data[0];
          default: ;
        endcase
      end
      if (!t_loaded && m_ctrl[0]) begin
        if (m_count == 32'd1) begin
          t_set = 1'b1;
          t_cnt = m_ctrl[1] ? m_load : 32'd0;
        end else if (m_count > 32'd1) begin
          t_cnt = m_count - 32'd1;
        end
      end
      m_irq   = m_exp & m_ctrl[2];
      m_exp   = t_set ? 1'b1 : (t_clr ? 1'b0 : m_exp);
      m_ctrl  = t_ctrl; m_load = t_load; m_count = t_cnt;
      cyc++;
    end
  end

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a & 8'hFC)
      8'h00:   return {29'd0, m_ctrl};
      8'h04:   return m_load;
      8'h08:   return m_count;
      8'h0C:   return {31'd0, m_exp};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_err(input logic wr, input logic [7:0] a);
    logic [7:0] o;
    o = a & 8'hFC;
    return (o > 8'h0C) || (wr && o == 8'h08);
  endfunction

  // Monitor: pops an expectation whenever the DUT completes a transfer.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
      if (apb.PREADY === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(e.name, apb.PRDATA, e.rdata);
`ifdef APB_TIMER_PSLVERR_EN
          chk({e.name, "_pslverr"}, {31'd0, apb.PSLVERR}, {31'd0, e.err});
`endif
        end
      end else begin
        chk("prdata_idle", apb.PRDATA, 32'd0);
`ifdef APB_TIMER_PSLVERR_EN
        chk("pslverr_idle", {31'd0, apb.PSLVERR}, 32'd0);
`endif
      end
    end
  end

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input string name);
    int edges;
    exp_t e;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = addr; apb.PWDATA = data; apb.PSTRB = strb;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    edges = 0;
    repeat (WC - 1) begin @(posedge PCLK); edges++; end
    #1;
    e.rdata = wr ? 32'd0 : m_read(addr);
    e.err   = m_err(wr, addr);
    e.name  = name;
    exp_q.push_back(e);
    while (1) begin
      @(negedge PCLK);
      if (apb.PREADY === 1'b1) break;
      if (edges > 20) break;
      @(posedge PCLK); edges++;
    end
    chk({name, "_latency"}, edges + 1, WC + 1);
    if (wr && edges <= 20) begin
      pend_addr = addr; pend_data = data; pend_strb = strb; pend_at = cyc;
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input string name);
    xfer(1'b0, a, 32'd0, 4'h0, name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Setup then drop PSEL in the first WAIT cycle; no completion may follow.
  task automatic abort_wr(input logic [7:0] a, input logic [31:0] d);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = a; apb.PWDATA = d; apb.PSTRB = 4'hF;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    idle(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] addrs [7];
    logic [7:0] a;
    logic [31:0] d;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'hFC, 8'h05};
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 8'h00; apb.PWDATA = 32'd0; apb.PSTRB = 4'h0;
    idle(3);
    PRESET = 1'b0;
    idle(1);
    chk("reset_pready", {31'd0, apb.PREADY}, 32'd0);
    chk("reset_irq", {31'd0, IRQ}, 32'd0);
    rd(8'h00, "reset_ctrl"); rd(8'h04, "reset_load");
    rd(8'h08, "reset_count"); rd(8'h0C, "reset_status");

    wr(8'h04, 32'h0000_0005);
    rd(8'h04, "load5"); rd(8'h08, "count5");

    wr(8'h04, 32'h0);
    xfer(1'b1, 8'h04, 32'h1234_5678, 4'b0101, "wr_strb");
    rd(8'h04, "load_strb");
    xfer(1'b1, 8'h04, 32'hFFFF_FFFF, 4'b0000, "wr_nostrb");
    rd(8'h04, "load_nostrb");

    wr(8'h04, 32'd3); wr(8'h00, 32'h5);
    for (int i = 0; i < 3; i++) rd(8'h08, "oneshot_count");
    rd(8'h0C, "oneshot_status");
    idle(4);
    rd(8'h08, "oneshot_hold");
    wr(8'h0C, 32'h1);
    idle(3);
    rd(8'h0C, "oneshot_cleared");

    wr(8'h00, 32'h0); wr(8'h04, 32'd2); wr(8'h00, 32'h3);
    for (int i = 0; i < 6; i++) begin
      rd(8'h08, "auto_count");
      xfer(1'b1, 8'h0C, 32'h1, 4'h1, "auto_w1c");
      rd(8'h0C, "auto_status");
      idle(i % 2);
    end

    rd(8'h10, "unmapped_rd");
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, "count_wr");
    wr(8'h00, 32'h0);
    abort_wr(8'h04, 32'h0000_00FF);
    rd(8'h04, "load_after_abort");

    wr(8'h04, 32'd3); wr(8'h00, 32'h5);
    idle(6);
    wr(8'h00, 32'h0); wr(8'h00, 32'h5);
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 8'h08;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #2; PRESET = 1'b1; #1;
    chk("rst_mid_pready", {31'd0, apb.PREADY}, 32'd0);
    chk("rst_mid_prdata", apb.PRDATA, 32'd0);
    chk("rst_mid_irq", {31'd0, IRQ}, 32'd0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    idle(2);
    PRESET = 1'b0;
    chk("rst_mid_queue", exp_q.size(), 32'd0);
    idle(1);
    rd(8'h00, "rst_ctrl"); rd(8'h04, "rst_load");
    rd(8'h08, "rst_count"); rd(8'h0C, "rst_status");

    for (int i = 0; i < 200; i++) begin
      a = addrs[$urandom_range(0, 6)];
      case ($urandom_range(0, 3))
        0: d = $urandom_range(0, 7);
        1: d = $urandom_range(0, 6);
        2: d = $urandom;
        default: d = 32'h1;
      endcase
      case ($urandom_range(0, 9))
        0: abort_wr(a, d);
        1, 2, 3, 4: xfer(1'b1, a, d, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, "rnd_wr");
        default: xfer(1'b0, a, 32'd0, 4'h0, "rnd_rd");
      endcase
      idle($urandom_range(0, 2));
    end

    idle(4);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
